ram_rd_checker: RTL and testbench
=================================

Name: ram_rd_checker

Overview:
Read-side verification engine for the on-chip block-RAM test path. On a start pulse it sweeps every RAM address through a synchronous read port and compares each returned word against the expected pattern, data = addr + seed. It counts mismatches, captures the first failing address and reports pass/fail. It sits beside the RAM write/pattern generator and drives the RAM's read port directly.

Parameters:
ADDR_WIDTH, 9, read address width
DATA_WIDTH, 16, RAM word width
DEPTH, 512, number of words checked (addresses 0..DEPTH-1); DEPTH <= 2^ADDR_WIDTH, DEPTH >= 2
RD_LATENCY, 1, cycles from rd_en/addr to valid ram_rd_data; range 1..4
ERR_WIDTH, 16, error counter width

Ports:
clk  in  1  system clock (50 MHz board clock)
rst_n  in  1  reset; synchronous, active-low
start  in  1  single-cycle request to begin a sweep; ignored unless idle
seed  in  DATA_WIDTH  pattern offset; sampled when start is accepted
ram_rd_en  out  1  RAM read enable
ram_rd_addr  out  ADDR_WIDTH  RAM read address
ram_rd_data  in  DATA_WIDTH  RAM read data, valid RD_LATENCY cycles after the request
busy  out  1  high from start acceptance through the DONE cycle
done  out  1  one-cycle pulse at end of sweep
pass  out  1  valid when done=1: 1 iff err_cnt==0; held until next start
err_cnt  out  ERR_WIDTH  mismatch count; saturates at all-ones
first_err_addr  out  ADDR_WIDTH  address of first mismatch; 0 if none
first_err_vld  out  1  a mismatch has been captured this sweep

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE; ram_rd_en=0, ram_rd_addr=0, busy=0, done=0, pass=0, err_cnt=0, first_err_addr=0, first_err_vld=0. Latency pipe is flushed. Reset mid-sweep aborts the sweep with no done pulse.
- FSM states: IDLE, READ, DRAIN, DONE.
- IDLE: if start=1, latch seed, clear err_cnt, first_err_* and pass, then go to READ. busy goes to 1 at the next edge.
- READ: ram_rd_en=1. ram_rd_addr is 0 on the first READ cycle and increments by 1 each cycle. After issuing addr DEPTH-1, go to DRAIN. READ lasts exactly DEPTH cycles.
- DRAIN: ram_rd_en=0. Lasts RD_LATENCY cycles, then go to DONE.
- DONE: done=1 and pass=(err_cnt==0) for one cycle, then return to IDLE; busy drops to 0 with the return to IDLE.
- Timing: if start is sampled at cycle t, done=1 in cycle t+DEPTH+RD_LATENCY+1.
- Compare pipeline: a RD_LATENCY-deep shift register carries (valid, addr) alongside each request. When the delayed valid=1, compare ram_rd_data with (delayed addr + seed) mod 2^DATA_WIDTH. The address is zero-extended to DATA_WIDTH, or truncated if wider.
- On mismatch: err_cnt+1, unless err_cnt is all-ones, in which case it holds. If first_err_vld=0, capture first_err_addr and set first_err_vld=1.
- Final compare happens in the last DRAIN cycle; err_cnt is final in the DONE cycle.
- start while busy: ignored, with no effect on the sweep or on seed. start in the DONE cycle: ignored. A start is accepted only in IDLE.
- ram_rd_addr holds its last value (DEPTH-1) after READ until the next start.
- Results (err_cnt, first_err_*, pass) stay stable in IDLE until the next accepted start.

Test Plan:
- Reset: hold rst_n=0 for 5 cycles mid-sweep -> all outputs 0 at the next edge, no done pulse, state IDLE; a later start runs a full sweep normally.
- Clean RAM: DEPTH=16, RD_LATENCY=1, RAM model preloaded with mem[a]=a+0x0100, seed=0x0100, start pulse at cycle t -> ram_rd_en high for cycles t+1..t+16 with addr 0..15; done at t+18; pass=1, err_cnt=0, first_err_vld=0.
- Corrupted words: same setup with mem[5]=0xDEAD and mem[12]=0x0000 -> done at t+18; err_cnt=2, first_err_addr=5, first_err_vld=1, pass=0.
- Latency: RD_LATENCY=3 model, clean RAM, DEPTH=16 -> done at t+20, err_cnt=0; repeat with mem[0] wrong -> err_cnt=1, first_err_addr=0.
- Wrap/saturation: ERR_WIDTH=4, DEPTH=32, seed=0xFFF8 with every word wrong -> err_cnt=15, first_err_addr=0. Then a clean RAM with seed=0xFFF8 (expected data wraps 0xFFF8..0x0017) -> pass=1.
- Start while busy: pulse start with seed=0x1234 at t+5 during a sweep -> ignored; sweep completes at t+18 using the original seed, and no second sweep follows.

Source files
------------

// File: rtl/ram_rd_checker.sv
`default_nettype none
// ============================================================================
// Module   : ram_rd_checker
// Brief    : Read-side block-RAM checker. Sweeps addresses 0..DEPTH-1 through
//            a synchronous read port, compares each word to addr + seed,
//            counts mismatches (saturating), records the first failing
//            address and reports pass/fail with a one-cycle done pulse.
// Revision : 1.0 - initial release
// ============================================================================
module ram_rd_checker #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 512,
    parameter int RD_LATENCY = 1,
    parameter int ERR_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] seed,
    output logic                  ram_rd_en,
    output logic [ADDR_WIDTH-1:0] ram_rd_addr,
    input  logic [DATA_WIDTH-1:0] ram_rd_data,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [ERR_WIDTH-1:0]  err_cnt,
    output logic [ADDR_WIDTH-1:0] first_err_addr,
    output logic                  first_err_vld
);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_read  = 2'd1;
    localparam logic [1:0] c_st_drain = 2'd2;
    localparam logic [1:0] c_st_done  = 2'd3;

    localparam logic [ADDR_WIDTH-1:0] c_last_addr  = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [2:0]            c_drain_last = 3'(RD_LATENCY - 1);
    localparam logic [ERR_WIDTH-1:0]  c_err_max    = '1;

    logic [1:0]            r_state;
    logic [DATA_WIDTH-1:0] r_seed;
    logic                  r_rd_en;
    logic [ADDR_WIDTH-1:0] r_rd_addr;
    logic [2:0]            r_drain_cnt;
    logic                  r_pass;
    logic [ERR_WIDTH-1:0]  r_err_cnt;
    logic [ADDR_WIDTH-1:0] r_first_addr;
    logic                  r_first_vld;

    // Request tracking pipe: entry RD_LATENCY-1 lines up with ram_rd_data
    logic [RD_LATENCY-1:0] r_pipe_vld;
    logic [ADDR_WIDTH-1:0] r_pipe_addr [RD_LATENCY];

    logic                  w_start_ok;
    logic [ADDR_WIDTH-1:0] w_cmp_addr;
    logic [DATA_WIDTH-1:0] w_expected;
    logic                  w_mismatch;

    assign w_start_ok = (r_state == c_st_idle) && start;
    assign w_cmp_addr = r_pipe_addr[RD_LATENCY-1];
    // Address is zero-extended or truncated to the data width before the add
    assign w_expected = DATA_WIDTH'(w_cmp_addr) + r_seed;
    assign w_mismatch = r_pipe_vld[RD_LATENCY-1] && (ram_rd_data != w_expected);

    // Sweep sequencer: issues one read per cycle, drains the latency, reports
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= c_st_idle;
            r_seed      <= '0;
            r_rd_en     <= 1'b0;
            r_rd_addr   <= '0;
            r_drain_cnt <= '0;
            r_pass      <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (start) begin
                        r_state   <= c_st_read;
                        r_seed    <= seed;
                        r_rd_en   <= 1'b1;
                        r_rd_addr <= '0;
                        r_pass    <= 1'b0;
                    end
                end
                c_st_read: begin
                    if (r_rd_addr == c_last_addr) begin
                        r_state     <= c_st_drain;
                        r_rd_en     <= 1'b0;
                        r_drain_cnt <= '0;
                    end else begin
                        r_rd_addr <= r_rd_addr + 1'b1;
                    end
                end
                c_st_drain: begin
                    if (r_drain_cnt == c_drain_last) begin
                        // Last compare lands this cycle, so fold it into pass
                        r_state <= c_st_done;
                        r_pass  <= (r_err_cnt == '0) && !w_mismatch;
                    end else begin
                        r_drain_cnt <= r_drain_cnt + 1'b1;
                    end
                end
                c_st_done: begin
                    r_state <= c_st_idle;
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    // Shift (valid, addr) of each request down the latency pipe
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < RD_LATENCY; i++) begin
                r_pipe_vld[i]  <= 1'b0;
                r_pipe_addr[i] <= '0;
            end
        end else begin
            r_pipe_vld[0]  <= r_rd_en;
            r_pipe_addr[0] <= r_rd_addr;
            for (int i = 1; i < RD_LATENCY; i++) begin
                r_pipe_vld[i]  <= r_pipe_vld[i-1];
                r_pipe_addr[i] <= r_pipe_addr[i-1];
            end
        end
    end

    // Error accounting: saturating count and first failing address
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_err_cnt    <= '0;
            r_first_addr <= '0;
            r_first_vld  <= 1'b0;
        end else if (w_start_ok) begin
            r_err_cnt    <= '0;
            r_first_addr <= '0;
            r_first_vld  <= 1'b0;
        end else if (w_mismatch) begin
            if (r_err_cnt != c_err_max) begin
                r_err_cnt <= r_err_cnt + 1'b1;
            end
            if (!r_first_vld) begin
                r_first_addr <= w_cmp_addr;
                r_first_vld  <= 1'b1;
            end
        end
    end

    assign ram_rd_en      = r_rd_en;
    assign ram_rd_addr    = r_rd_addr;
    assign busy           = (r_state != c_st_idle);
    assign done           = (r_state == c_st_done);
    assign pass           = r_pass;
    assign err_cnt        = r_err_cnt;
    assign first_err_addr = r_first_addr;
    assign first_err_vld  = r_first_vld;

endmodule
`default_nettype wire

// File: tb/tb_ram_rd_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_rd_checker
// Brief    : Self-checking bench for ram_rd_checker. Three instances cover
//            latency 1 / latency 3 / 4-bit saturating error counter; each has
//            its own RAM model. Expected results are derived from the RAM
//            contents and the addr + seed rule.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_rd_checker;

    localparam int c_dep [3] = '{16, 16, 32};
    localparam int c_lat [3] = '{1, 3, 1};
    localparam int c_ew  [3] = '{16, 16, 4};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  start;
    logic [15:0] seed [3];
    logic        rd_en [3];
    logic [8:0]  rd_addr [3];
    logic        busy [3];
    logic        done [3];
    logic        pass [3];
    logic [8:0]  faddr [3];
    logic        fvld [3];
    logic [15:0] errc0;
    logic [15:0] errc1;
    logic [3:0]  errc2;

    logic [15:0] mem [3][32];
    logic [15:0] dq  [3][4];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // RAM models: read data appears c_lat[g] cycles after the request
    always @(posedge clk) begin
        for (int g = 0; g < 3; g++) begin
            dq[g][0] <= rd_en[g] ? mem[g][rd_addr[g][4:0]] : 16'h0000;
            for (int k = 1; k < 4; k++) dq[g][k] <= dq[g][k-1];
        end
    end

    ram_rd_checker #(.ADDR_WIDTH(9), .DATA_WIDTH(16), .DEPTH(16), .RD_LATENCY(1), .ERR_WIDTH(16)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .seed(seed[0]),
        .ram_rd_en(rd_en[0]), .ram_rd_addr(rd_addr[0]), .ram_rd_data(dq[0][0]),
        .busy(busy[0]), .done(done[0]), .pass(pass[0]), .err_cnt(errc0),
        .first_err_addr(faddr[0]), .first_err_vld(fvld[0]));

    ram_rd_checker #(.ADDR_WIDTH(9), .DATA_WIDTH(16), .DEPTH(16), .RD_LATENCY(3), .ERR_WIDTH(16)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .seed(seed[1]),
        .ram_rd_en(rd_en[1]), .ram_rd_addr(rd_addr[1]), .ram_rd_data(dq[1][2]),
        .busy(busy[1]), .done(done[1]), .pass(pass[1]), .err_cnt(errc1),
        .first_err_addr(faddr[1]), .first_err_vld(fvld[1]));

    ram_rd_checker #(.ADDR_WIDTH(9), .DATA_WIDTH(16), .DEPTH(32), .RD_LATENCY(1), .ERR_WIDTH(4)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start[2]), .seed(seed[2]),
        .ram_rd_en(rd_en[2]), .ram_rd_addr(rd_addr[2]), .ram_rd_data(dq[2][0]),
        .busy(busy[2]), .done(done[2]), .pass(pass[2]), .err_cnt(errc2),
        .first_err_addr(faddr[2]), .first_err_vld(fvld[2]));

    function automatic logic [15:0] get_err(input int g);
        if (g == 0) return errc0;
        if (g == 1) return errc1;
        return {12'h000, errc2};
    endfunction

    task automatic chk(input string tag, input int g, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s[u%0d]: observed %0h expected %0h", tag, g, obs, exp);
        end
    endtask

    task automatic fill(input int g, input logic [15:0] sd);
        for (int a = 0; a < 32; a++) mem[g][a] = 16'(a + int'(sd));
    endtask

    task automatic chk_zero(input int g);
        chk("rst_rd_en", g, rd_en[g], 0);
        chk("rst_addr",  g, rd_addr[g], 0);
        chk("rst_busy",  g, busy[g], 0);
        chk("rst_done",  g, done[g], 0);
        chk("rst_pass",  g, pass[g], 0);
        chk("rst_err",   g, get_err(g), 0);
        chk("rst_faddr", g, faddr[g], 0);
        chk("rst_fvld",  g, fvld[g], 0);
    endtask

    // One full sweep with cycle-by-cycle checks against the reference model
    task automatic sweep(input int g, input logic [15:0] sd, input bit probe);
        int dep, lat, fin, cnt, first, mx;
        logic [15:0] exp_err;
        dep = c_dep[g]; lat = c_lat[g]; fin = dep + lat + 1;
        mx = (1 << c_ew[g]) - 1;
        cnt = 0; first = -1;
        for (int a = 0; a < dep; a++) begin
            if (mem[g][a] !== 16'(a + int'(sd))) begin
                if (first < 0) first = a;
                cnt++;
            end
        end
        exp_err = 16'((cnt > mx) ? mx : cnt);
        if (first < 0) first = 0;

        @(negedge clk);
        seed[g]  = sd;
        start[g] = 1'b1;
        @(posedge clk);
        #1;
        start[g] = 1'b0;
        seed[g]  = sd ^ 16'h5A5A;
        for (int k = 1; k <= fin + 4; k++) begin
            if (k > 1) begin
                @(posedge clk);
                #1;
                start[g] = 1'b0;
            end
            chk("rd_en", g, rd_en[g], (k <= dep) ? 1 : 0);
            chk("rd_addr", g, rd_addr[g], (k <= dep) ? k - 1 : dep - 1);
            chk("done", g, done[g], (k == fin) ? 1 : 0);
            chk("busy", g, busy[g], (k <= fin) ? 1 : 0);
            if (k == fin || k == fin + 4) begin
                chk("err_cnt", g, get_err(g), exp_err);
                chk("first_err_addr", g, faddr[g], first);
                chk("first_err_vld", g, fvld[g], (cnt > 0) ? 1 : 0);
                chk("pass", g, pass[g], (cnt == 0) ? 1 : 0);
            end
            if (probe && k == 5) begin
                seed[g]  = 16'h1234;
                start[g] = 1'b1;
            end
        end
    endtask

    initial begin
        start = 3'b000;
        for (int g = 0; g < 3; g++) seed[g] = 16'h0000;
        fill(0, 16'h0100);
        fill(1, 16'h0100);
        fill(2, 16'hFFF8);

        // Power-on reset
        repeat (3) @(posedge clk);
        #1;
        for (int g = 0; g < 3; g++) chk_zero(g);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset in the middle of a sweep that has already seen an error
        mem[0][1] = 16'hBEEF;
        @(negedge clk);
        seed[0]  = 16'h0100;
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        repeat (6) @(negedge clk);
        chk("pre_rst_err", 0, get_err(0), 1);
        rst_n = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            chk_zero(0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            chk("post_rst_done", 0, done[0], 0);
            chk("post_rst_rd_en", 0, rd_en[0], 0);
        end
        fill(0, 16'h0100);

        // Clean RAM, then two corrupted words
        sweep(0, 16'h0100, 1'b0);
        mem[0][5]  = 16'hDEAD;
        mem[0][12] = 16'h0000;
        sweep(0, 16'h0100, 1'b0);

        // Start while busy is ignored; original seed is used
        fill(0, 16'h0100);
        sweep(0, 16'h0100, 1'b1);

        // Latency 3: clean, then word 0 wrong
        sweep(1, 16'h0100, 1'b0);
        mem[1][0] = 16'h0000;
        sweep(1, 16'h0100, 1'b0);

        // 4-bit counter saturation with every word wrong, then wrap-around clean
        for (int a = 0; a < 32; a++) mem[2][a] = 16'(a + 32'hFFF9);
        sweep(2, 16'hFFF8, 1'b0);
        fill(2, 16'hFFF8);
        sweep(2, 16'hFFF8, 1'b0);

        // Randomized sweeps with random seeds and random corruptions
        for (int r = 0; r < 6; r++) begin
            int g, nbad;
            logic [15:0] sd;
            g  = int'($urandom_range(0, 2));
            sd = 16'($urandom);
            fill(g, sd);
            nbad = int'($urandom_range(0, 20));
            for (int j = 0; j < nbad; j++)
                mem[g][$urandom_range(0, c_dep[g] - 1)] = 16'($urandom);
            sweep(g, sd, r[0]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
